// File: rtl/cc_syscfg_ctrl.sv
// rtl/cc_syscfg_ctrl.sv - APB system-configuration block: per-core boot address and soft-reset sequencing
module cc_syscfg_ctrl #(
  parameter int              CC_NUM          = 2,
  parameter int              APB_ADDR_WIDTH  = 12,
  parameter int              RST_HOLD_CYCLES = 16,
  parameter logic [31:0]     BOOT_RESET_VAL  = 32'h8000_0000,
  parameter logic [CC_NUM-1:0] RST_INIT_HOLD = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  input  logic                      pwrite_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic [CC_NUM*32-1:0]      cc_boot_o,
  output logic [CC_NUM-1:0]         cc_rst_no
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PULSE = 2'd1,
    ST_HELD  = 2'd2
  } state_e;

  // Core 0 must always come out of power-on reset running.
  localparam logic [CC_NUM-1:0] INIT_HOLD  = RST_INIT_HOLD & ~CC_NUM'(1);
  localparam logic [7:0]        PULSE_LOAD = 8'(RST_HOLD_CYCLES - 1);
  localparam logic [7:0]        CC_NUM_B   = 8'(CC_NUM);

  logic       w_access;
  logic [3:0] w_core;
  logic [1:0] w_reg;
  logic       w_core_space;
  logic       w_info;
  logic       w_core_ok;
  logic       w_err_cond;
  logic       w_wr_ok;
  logic       w_wr_boot;
  logic       w_wr_ctrl;
  logic       w_unused;
  logic [31:0] w_rdata;

  logic [31:0] w_boot   [CC_NUM];
  logic        w_hold   [CC_NUM];
  logic [15:0] w_status [CC_NUM];

  assign w_access     = psel_i & penable_i;
  assign w_core       = paddr_i[7:4];
  assign w_reg        = paddr_i[3:2];
  assign w_core_space = (paddr_i[APB_ADDR_WIDTH-1:8] == '0);
  assign w_info       = ({paddr_i[APB_ADDR_WIDTH-1:2], 2'b00} == APB_ADDR_WIDTH'(256));
  assign w_core_ok    = ({1'b0, w_core} < 5'(CC_NUM));
  assign w_unused     = ^paddr_i[1:0];

  assign w_err_cond = w_info ? pwrite_i
                             : (~w_core_space | ~w_core_ok | (w_reg == 2'd3) |
                                ((w_reg == 2'd2) & pwrite_i));

  assign w_wr_ok   = w_access & pwrite_i & ~w_err_cond & w_core_space;
  assign w_wr_boot = w_wr_ok & (w_reg == 2'd0);
  assign w_wr_ctrl = w_wr_ok & (w_reg == 2'd1);

  assign pready_o  = 1'b1;
  assign pslverr_o = w_access & w_err_cond;
  assign prdata_o  = w_rdata;

  always_comb begin
    w_rdata = '0;
    if (w_access && !pwrite_i && !w_err_cond) begin
      if (w_info) begin
        w_rdata = {16'h5C01, 8'd0, CC_NUM_B};
      end else begin
        for (int n = 0; n < CC_NUM; n++) begin
          if (w_core == 4'(n)) begin
            case (w_reg)
              2'd0:    w_rdata = w_boot[n];
              2'd1:    w_rdata = {30'd0, w_hold[n], 1'b0};
              2'd2:    w_rdata = {16'd0, w_status[n]};
              default: w_rdata = '0;
            endcase
          end
        end
      end
    end
  end

  for (genvar g = 0; g < CC_NUM; g++) begin : g_core
    logic        w_sel;
    logic        w_ctrl_wr;
    logic        w_req;
    logic        w_hold_set;
    state_e      r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_rcnt;
    logic        r_rst_n;
    logic        r_hold;
    logic [31:0] r_boot;
    logic [31:0] r_boot_o;

    assign w_sel      = (w_core == 4'(g));
    assign w_ctrl_wr  = w_wr_ctrl & w_sel;
    assign w_req      = w_ctrl_wr & pwdata_i[0];
    assign w_hold_set = w_ctrl_wr & pwdata_i[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_boot <= BOOT_RESET_VAL;
        r_hold <= INIT_HOLD[g];
      end else begin
        if (w_wr_boot && w_sel) r_boot <= pwdata_i;
        if (w_ctrl_wr)          r_hold <= pwdata_i[1];
      end
    end

    // r_rst_n tracks the next state so the core reset is glitch-free and registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state  <= INIT_HOLD[g] ? ST_HELD : ST_RUN;
        r_cnt    <= '0;
        r_rcnt   <= '0;
        r_rst_n  <= ~INIT_HOLD[g];
        r_boot_o <= BOOT_RESET_VAL;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (w_req || w_hold_set) begin
              r_state <= ST_PULSE;
              r_cnt   <= PULSE_LOAD;
              r_rst_n <= 1'b0;
              if (r_rcnt != 8'hFF) r_rcnt <= r_rcnt + 8'd1;
            end
          end
          ST_PULSE: begin
            if (w_req) begin
              r_cnt <= PULSE_LOAD;
            end else if (r_cnt != 8'd0) begin
              r_cnt <= r_cnt - 8'd1;
            end else if (r_hold) begin
              r_state <= ST_HELD;
            end else begin
              r_state  <= ST_RUN;
              r_rst_n  <= 1'b1;
              r_boot_o <= r_boot;
            end
          end
          ST_HELD: begin
            if (!r_hold) begin
              r_state  <= ST_RUN;
              r_rst_n  <= 1'b1;
              r_boot_o <= r_boot;
            end
          end
          default: begin
            r_state <= ST_HELD;
            r_rst_n <= 1'b0;
          end
        endcase
      end
    end

    assign w_boot[g]            = r_boot;
    assign w_hold[g]            = r_hold;
    assign w_status[g]          = {r_rcnt, 5'd0, r_state, ~r_rst_n};
    assign cc_boot_o[32*g +: 32] = r_boot_o;
    assign cc_rst_no[g]          = r_rst_n;
  end

endmodule

// File: tb/tb_cc_syscfg_ctrl.sv
// tb/tb_cc_syscfg_ctrl.sv - scoreboard bench for cc_syscfg_ctrl with a cycle-level reference model
module tb_cc_syscfg_ctrl;

  localparam int CC = 2;
  localparam int AW = 12;
  localparam int H  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;
  logic [CC*32-1:0] cc_boot;
  logic [CC-1:0] cc_rst_n;

  always #5 clk = ~clk;

  cc_syscfg_ctrl #(
    .CC_NUM(CC), .APB_ADDR_WIDTH(AW), .RST_HOLD_CYCLES(H),
    .BOOT_RESET_VAL(32'h8000_0000), .RST_INIT_HOLD('0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr), .pwdata_i(pwdata),
    .pwrite_i(pwrite), .psel_i(psel), .penable_i(penable),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .cc_boot_o(cc_boot), .cc_rst_no(cc_rst_n)
  );

  typedef struct { bit rd; logic [31:0] data; bit err; } apb_exp_t;
  typedef struct { logic [CC-1:0] rst; logic [CC*32-1:0] boot; } out_exp_t;

  apb_exp_t apb_q[$];
  out_exp_t out_q[$];
  apb_exp_t ae, ae_push;
  out_exp_t oe, oe_push;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_boot [CC];
  logic [31:0] m_lane [CC];
  bit          m_hold [CC];
  bit          m_held [CC];
  int          m_pulse[CC];
  int          m_cnt  [CC];

  int run0 = 0;
  int last_low0 = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic void model_reset();
    for (int n = 0; n < CC; n++) begin
      m_boot[n] = 32'h8000_0000; m_lane[n] = 32'h8000_0000;
      m_hold[n] = 0; m_held[n] = 0; m_pulse[n] = 0; m_cnt[n] = 0;
    end
  endfunction

  function automatic bit m_run(int n);
    return (m_pulse[n] == 0) && !m_held[n];
  endfunction

  function automatic bit exp_err(int addr, bit wr);
    int a = addr & ~3;
    int n = a >> 4;
    int r = (a >> 2) & 3;
    if (a == 256) return wr;
    if (a > 255)  return 1'b1;
    return (n >= CC) || (r == 3) || (r == 2 && wr);
  endfunction

  function automatic logic [31:0] exp_rdata(int addr);
    int a = addr & ~3;
    int n = a >> 4;
    int r = (a >> 2) & 3;
    int st;
    if (exp_err(addr, 1'b0)) return 32'd0;
    if (a == 256) return 32'h5C01_0000 | CC;
    if (r == 0) return m_boot[n];
    if (r == 1) return m_hold[n] ? 32'd2 : 32'd0;
    st = (m_pulse[n] > 0) ? 1 : (m_held[n] ? 2 : 0);
    return 32'((m_cnt[n] << 8) | (st << 1) | (m_run(n) ? 0 : 1));
  endfunction

  // Advances the model across one clock edge using the bus values present in the ending cycle.
  function automatic void model_step();
    int  a  = int'(paddr) & ~3;
    int  wn = a >> 4;
    int  wr = (a >> 2) & 3;
    bit  wr_ok = psel && penable && pwrite && !exp_err(a, 1'b1) && (a < 256);
    for (int n = 0; n < CC; n++) begin
      bit ctrl_w = wr_ok && (wn == n) && (wr == 1);
      bit req    = ctrl_w && pwdata[0];
      bit hset   = ctrl_w && pwdata[1];
      if (m_pulse[n] > 0) begin
        if (req) m_pulse[n] = H;
        else begin
          m_pulse[n]--;
          if (m_pulse[n] == 0) begin
            if (m_hold[n]) m_held[n] = 1;
            else m_lane[n] = m_boot[n];
          end
        end
      end else if (m_held[n]) begin
        if (!m_hold[n]) begin m_held[n] = 0; m_lane[n] = m_boot[n]; end
      end else if (req || hset) begin
        m_pulse[n] = H;
        if (m_cnt[n] < 255) m_cnt[n]++;
      end
      if (ctrl_w) m_hold[n] = pwdata[1];
      if (wr_ok && (wn == n) && (wr == 0)) m_boot[n] = pwdata;
    end
    for (int n = 0; n < CC; n++) begin
      oe_push.rst[n] = m_run(n);
      oe_push.boot[32*n +: 32] = m_lane[n];
    end
    out_q.push_back(oe_push);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic idle(int n);
    psel = 0; penable = 0; pwrite = 0;
    repeat (n) tick();
  endtask

  task automatic apb(bit wr, int addr, logic [31:0] data, output logic [31:0] rdata);
    psel = 1; penable = 0; pwrite = wr; paddr = AW'(addr); pwdata = data;
    tick();
    penable = 1;
    ae_push.rd   = !wr;
    ae_push.data = wr ? 32'd0 : exp_rdata(addr);
    ae_push.err  = exp_err(addr, wr);
    apb_q.push_back(ae_push);
    #2 rdata = prdata;
    tick();
    psel = 0; penable = 0; pwrite = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_q.size() > 0) begin
        oe = out_q.pop_front();
        check("cc_rst_no", 64'(cc_rst_n), 64'(oe.rst));
        check("cc_boot_o", 64'(cc_boot), 64'(oe.boot));
      end
      if (psel && penable) begin
        if (apb_q.size() == 0) begin
          n_checks++;
          $display("FAIL apb_q: access seen with no queued expectation");
        end else begin
          ae = apb_q.pop_front();
          check("pready", 64'(pready), 64'd1);
          check("pslverr", 64'(pslverr), 64'(ae.err));
          if (ae.rd) check("prdata", 64'(prdata), 64'(ae.data));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n !== 1'b1) run0 = 0;
    else if (!cc_rst_n[0]) run0++;
    else if (run0 != 0) begin last_low0 = run0; run0 = 0; end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          addr;
    logic [31:0] data;
    bit          wr;
    rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset cc_rst_no", 64'(cc_rst_n), 64'h3);
    check("reset lane0", 64'(cc_boot[31:0]), 64'h8000_0000);
    check("reset lane1", 64'(cc_boot[63:32]), 64'h8000_0000);
    check("reset prdata", 64'(prdata), 64'd0);
    check("reset pslverr", 64'(pslverr), 64'd0);
    rst_n = 1;

    apb(0, 'h100, 0, rd);
    check("INFO", 64'(rd), 64'h5C01_0002);
    apb(0, 'h008, 0, rd);
    check("STATUS_0 after reset", 64'(rd), 64'd0);

    apb(1, 'h000, 32'h0001_0000, rd);
    apb(1, 'h004, 32'h1, rd);
    check("lane0 held during pulse", 64'(cc_boot[31:0]), 64'h8000_0000);
    idle(20);
    check("pulse width core0", 64'(last_low0), 64'd16);
    check("lane0 after release", 64'(cc_boot[31:0]), 64'h0001_0000);
    apb(0, 'h008, 0, rd);
    check("STATUS_0 count", 64'(rd), 64'h100);

    apb(1, 'h014, 32'h3, rd);
    idle(18);
    apb(0, 'h018, 0, rd);
    check("STATUS_1 held", 64'(rd), 64'h105);
    apb(1, 'h014, 32'h0, rd);
    check("core1 still held at T+1", 64'(cc_rst_n[1]), 64'd0);
    tick();
    check("core1 released at T+2", 64'(cc_rst_n[1]), 64'd1);
    idle(2);

    apb(1, 'h004, 32'h1, rd);
    idle(3);
    apb(1, 'h004, 32'h1, rd);
    idle(25);
    check("re-request low period", 64'(last_low0), 64'd21);
    apb(0, 'h008, 0, rd);
    check("re-request count", 64'(rd[15:8]), 64'd2);

    apb(0, 'h020, 0, rd);          check("err rd 0x020", 64'(rd), 64'd0);
    apb(1, 'h008, 32'hFFFF_FFFF, rd);
    apb(0, 'h00C, 0, rd);          check("err rd 0x00C", 64'(rd), 64'd0);
    apb(1, 'h00C, 32'h1, rd);
    apb(0, 'h104, 0, rd);          check("err rd 0x104", 64'(rd), 64'd0);
    apb(1, 'h104, 32'h1, rd);
    apb(1, 'h100, 32'h1, rd);
    apb(1, 'h024, 32'h3, rd);
    idle(3);
    apb(0, 'h008, 0, rd);
    check("STATUS_0 untouched by errors", 64'(rd), 64'h200);

    repeat (150) begin
      if ($urandom_range(0, 7) == 0) addr = int'($urandom_range(0, 4095));
      else if ($urandom_range(0, 7) == 0) addr = 'h100 + int'($urandom_range(0, 7));
      else addr = int'($urandom_range(0, 2) * 16 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
      wr   = 1'($urandom_range(0, 1));
      data = (((addr >> 2) & 3) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      apb(wr, addr, data, rd);
      idle(int'($urandom_range(0, 4)));
    end
    apb(1, 'h004, 0, rd);
    apb(1, 'h014, 0, rd);
    idle(40);

    repeat (300) begin
      apb(1, 'h004, 32'h1, rd);
      idle(17);
    end
    apb(0, 'h008, 0, rd);
    check("count saturates", 64'(rd[15:8]), 64'd255);

    apb(1, 'h004, 32'h1, rd);
    apb(1, 'h014, 32'h1, rd);
    idle(3);
    #2 rst_n = 0;
    out_q.delete();
    apb_q.delete();
    model_reset();
    #1;
    check("async reset cc_rst_no", 64'(cc_rst_n), 64'h3);
    check("async reset lane0", 64'(cc_boot[31:0]), 64'h8000_0000);
    check("async reset lane1", 64'(cc_boot[63:32]), 64'h8000_0000);
    check("async reset pslverr", 64'(pslverr), 64'd0);
    repeat (2) tick();
    rst_n = 1;
    apb(0, 'h008, 0, rd);
    check("STATUS_0 after reset", 64'(rd), 64'd0);
    apb(0, 'h000, 0, rd);
    check("BOOT_0 after reset", 64'(rd), 64'h8000_0000);
    idle(2);
    check("apb_q drained", 64'(apb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
